// File: rtl/nvdla_csb_master.sv
// ============================================================================
// Module   : nvdla_csb_master
// Brief    : CSB command sequencer with a command FIFO; an optional response
//            watchdog is compiled in with NVDLA_CSB_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module nvdla_csb_master #(
   parameter int unsigned FIFO_DEPTH     = 4,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        clear_i,
   input  logic        cmd_valid_i,
   output logic        cmd_ready_o,
   input  logic [31:0] cmd_addr_i,
   input  logic [31:0] cmd_wdat_i,
   input  logic        cmd_write_i,
   output logic        csb_valid_o,
   input  logic        csb_ready_i,
   output logic [15:0] csb_addr_o,
   output logic [31:0] csb_wdat_o,
   output logic        csb_write_o,
   output logic        csb_nposted_o,
   input  logic        csb_rvalid_i,
   input  logic [31:0] csb_rdata_i,
   input  logic        csb_wr_complete_i,
   output logic        rsp_valid_o,
   input  logic        rsp_ready_i,
   output logic [31:0] rsp_data_o,
   output logic        rsp_write_o,
   output logic        rsp_error_o,
   output logic        busy_o,
   output logic        unexp_o
);

   localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W   = PTR_W + 1;
   localparam int unsigned ENTRY_W = 16 + 32 + 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_RSP  = 2'd3
   } state_e;

   state_e               state_q, state_d;
   logic [ENTRY_W-1:0]   mem_q [FIFO_DEPTH];
   logic [ENTRY_W-1:0]   mem_d [FIFO_DEPTH];
   logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]     count_q, count_d;
   logic                 csb_valid_q, csb_valid_d;
   logic [15:0]          csb_addr_q, csb_addr_d;
   logic [31:0]          csb_wdat_q, csb_wdat_d;
   logic                 csb_write_q, csb_write_d;
   logic                 rsp_valid_q, rsp_valid_d;
   logic [31:0]          rsp_data_q, rsp_data_d;
   logic                 rsp_write_q, rsp_write_d;
   logic                 unexp_q, unexp_d;
   logic                 push, pop, match, wrong_kind;
   logic [ENTRY_W-1:0]   head;
   logic                 unused_addr_bits;

`ifdef NVDLA_CSB_TIMEOUT_EN
   localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES) + 1;
   logic [TO_W-1:0]      to_cnt_q, to_cnt_d;
   logic                 rsp_error_q, rsp_error_d;
`else
   localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

   assign unused_addr_bits = ^{cmd_addr_i[31:18], cmd_addr_i[1:0]};

   assign cmd_ready_o   = (count_q != CNT_W'(FIFO_DEPTH));
   assign push          = cmd_valid_i & cmd_ready_o;
   assign head          = mem_q[rd_ptr_q];
   // The kind of the outstanding request is held in csb_write_q after issue.
   assign match         = csb_write_q ? csb_wr_complete_i : csb_rvalid_i;
   assign wrong_kind    = csb_write_q ? csb_rvalid_i : csb_wr_complete_i;

   always_comb begin
      state_d     = state_q;
      mem_d       = mem_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      csb_valid_d = csb_valid_q;
      csb_addr_d  = csb_addr_q;
      csb_wdat_d  = csb_wdat_q;
      csb_write_d = csb_write_q;
      rsp_valid_d = rsp_valid_q;
      rsp_data_d  = rsp_data_q;
      rsp_write_d = rsp_write_q;
      unexp_d     = unexp_q;
      pop         = 1'b0;
`ifdef NVDLA_CSB_TIMEOUT_EN
      to_cnt_d    = to_cnt_q;
      rsp_error_d = rsp_error_q;
`endif

      case (state_q)
         ST_IDLE: begin
            if (count_q != '0) state_d = ST_REQ;
         end
         ST_REQ: begin
            csb_valid_d = 1'b1;
            // Load the head only before valid rises so the request holds still.
            if (!csb_valid_q) begin
               csb_addr_d  = head[ENTRY_W-1 -: 16];
               csb_wdat_d  = head[32:1];
               csb_write_d = head[0];
            end
            if (csb_valid_q && csb_ready_i) begin
               pop         = 1'b1;
               csb_valid_d = 1'b0;
               state_d     = ST_WAIT;
`ifdef NVDLA_CSB_TIMEOUT_EN
               to_cnt_d    = '0;
`endif
            end
         end
         ST_WAIT: begin
            if (wrong_kind) unexp_d = 1'b1;
            if (match) begin
               rsp_data_d  = csb_write_q ? 32'h0 : csb_rdata_i;
               rsp_write_d = csb_write_q;
               state_d     = ST_RSP;
`ifdef NVDLA_CSB_TIMEOUT_EN
               rsp_error_d = 1'b0;
            end else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
               rsp_data_d  = 32'hDEAD_BEEF;
               rsp_write_d = csb_write_q;
               rsp_error_d = 1'b1;
               state_d     = ST_RSP;
            end else begin
               to_cnt_d    = to_cnt_q + 1'b1;
`endif
            end
         end
         default: begin
            rsp_valid_d = 1'b1;
            if (rsp_valid_q && rsp_ready_i) begin
               rsp_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end
         end
      endcase

      if ((state_q != ST_WAIT) && (csb_rvalid_i || csb_wr_complete_i)) unexp_d = 1'b1;

      if (push) begin
         mem_d[wr_ptr_q] = {cmd_addr_i[17:2], cmd_wdat_i, cmd_write_i};
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
   end

   always_ff @(posedge clk_i) begin
      mem_q <= mem_d;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni || clear_i) begin
         state_q     <= ST_IDLE;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         csb_valid_q <= 1'b0;
         csb_addr_q  <= '0;
         csb_wdat_q  <= '0;
         csb_write_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_write_q <= 1'b0;
         unexp_q     <= 1'b0;
`ifdef NVDLA_CSB_TIMEOUT_EN
         to_cnt_q    <= '0;
         rsp_error_q <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         csb_valid_q <= csb_valid_d;
         csb_addr_q  <= csb_addr_d;
         csb_wdat_q  <= csb_wdat_d;
         csb_write_q <= csb_write_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         rsp_write_q <= rsp_write_d;
         unexp_q     <= unexp_d;
`ifdef NVDLA_CSB_TIMEOUT_EN
         to_cnt_q    <= to_cnt_d;
         rsp_error_q <= rsp_error_d;
`endif
      end
   end

`ifdef NVDLA_CSB_TIMEOUT_EN
   assign rsp_error_o = rsp_error_q;
`else
   assign rsp_error_o = 1'b0;
`endif

   assign csb_valid_o   = csb_valid_q;
   assign csb_addr_o    = csb_addr_q;
   assign csb_wdat_o    = csb_wdat_q;
   assign csb_write_o   = csb_write_q;
   assign csb_nposted_o = 1'b1;
   assign rsp_valid_o   = rsp_valid_q;
   assign rsp_data_o    = rsp_data_q;
   assign rsp_write_o   = rsp_write_q;
   assign unexp_o       = unexp_q;
   assign busy_o        = (count_q != '0) || (state_q != ST_IDLE);

endmodule

`default_nettype wire
